arb21_stage: RTL and testbench

Two-channel round-robin arbiter with a one-entry registered output, placed directly upstream of the 2:1 mux datapath. It accepts valid/ready traffic on channels A and B, picks one transfer per cycle with fair alternation, and registers the winning data. It exports the winner's select bit `s` so downstream `mux21` instances steer sideband signals consistently with the data. The select follows the mux convention: `s=0` selects A, `s=1` selects B.

---
 rtl/arb21_stage.sv | 83 ++++++++
 tb/tb_arb21_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/arb21_stage.sv
// arb21_stage: two-channel round-robin arbiter with a one-entry registered output.
// The registered select `s` tracks which channel the current output entry came from
// (0 = A, 1 = B) so downstream 2:1 muxes can steer sideband data consistently.
module arb21_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic             s
);

  typedef enum logic {
    PriA = 1'b0,
    PriB = 1'b1
  } pri_e;

  pri_e             pri_q;
  logic             o_valid_q;
  logic [WIDTH-1:0] o_data_q;
  logic             s_q;

  logic             load;
  logic             grant_a;
  logic             grant_b;

  // Grant decode: register free or draining this cycle, tie broken by the priority pointer.
  // Readies are forced low while reset is asserted so nothing is accepted and lost.
  always_comb begin
    load    = ~o_valid_q | o_ready;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && load) begin
      if (a_valid && b_valid) begin
        grant_a = (pri_q == PriA);
        grant_b = (pri_q == PriB);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // Output register and priority pointer; reset wins over any grant or drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      s_q       <= 1'b0;
      pri_q     <= PriA;
    end else if (load) begin
      if (grant_a) begin
        o_valid_q <= 1'b1;
        o_data_q  <= a_data;
        s_q       <= 1'b0;
        pri_q     <= PriB;
      end else if (grant_b) begin
        o_valid_q <= 1'b1;
        o_data_q  <= b_data;
        s_q       <= 1'b1;
        pri_q     <= PriA;
      end else begin
        // Drained with nothing to refill: data, select and pointer hold.
        o_valid_q <= 1'b0;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign s       = s_q;

endmodule

// File: tb/tb_arb21_stage.sv
// tb_arb21_stage: directed steps plus random traffic against a reference model and
// an in-order scoreboard of accepted transfers.
module tb_arb21_stage;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ready;
  logic             b_valid = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_ready = 1'b0;
  logic             s;

  arb21_stage #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .s       (s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Scoreboard entries are {s, data}; front is the entry expected in the output register.
  logic [WIDTH:0]   sb[$];
  logic             m_known = 1'b0;
  logic             m_ov = 1'b0;
  logic             m_pri = 1'b0;
  logic             m_s = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational/registered outputs at negedge, advance the model at posedge.
  task automatic tick();
    logic           ld;
    logic           ga;
    logic           gb;
    logic [WIDTH:0] ent;
    @(negedge clk);
    ld = !m_ov || o_ready;
    ga = rst_n && ld && a_valid && (!b_valid || !m_pri);
    gb = rst_n && ld && b_valid && (!a_valid || m_pri);
    check("a_ready", {31'd0, a_ready}, {31'd0, ga});
    check("b_ready", {31'd0, b_ready}, {31'd0, gb});
    check("a_ready_without_valid", {31'd0, a_ready & ~a_valid}, 32'd0);
    check("b_ready_without_valid", {31'd0, b_ready & ~b_valid}, 32'd0);
    if (m_known) begin
      check("o_valid", {31'd0, o_valid}, {31'd0, m_ov});
      check("o_data", {24'd0, o_data}, {24'd0, m_data});
      check("s", {31'd0, s}, {31'd0, m_s});
      if (rst_n && m_ov && o_ready) begin
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          ent = sb.pop_front();
          check("sb_data", {24'd0, o_data}, {24'd0, ent[WIDTH-1:0]});
          check("sb_s", {31'd0, s}, {31'd0, ent[WIDTH]});
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1'b1;
      m_ov    = 1'b0;
      m_data  = '0;
      m_s     = 1'b0;
      m_pri   = 1'b0;
      sb.delete();
    end else if (ld) begin
      if (ga) begin
        sb.push_back({1'b0, a_data});
        m_ov = 1'b1; m_data = a_data; m_s = 1'b0; m_pri = 1'b1;
      end else if (gb) begin
        sb.push_back({1'b1, b_data});
        m_ov = 1'b1; m_data = b_data; m_s = 1'b1; m_pri = 1'b0;
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  logic [WIDTH-1:0] alt_data[4];
  logic             alt_s[4];

  initial begin
    alt_data[0] = 8'h11; alt_data[1] = 8'h22; alt_data[2] = 8'h11; alt_data[3] = 8'h22;
    alt_s[0] = 1'b0; alt_s[1] = 1'b1; alt_s[2] = 1'b0; alt_s[3] = 1'b1;

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_data", {24'd0, o_data}, 32'd0);
    check("rst_s", {31'd0, s}, 32'd0);

    // Both valid, fair alternation starting with A
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("alt_valid", {31'd0, o_valid}, 32'd1);
      check("alt_data", {24'd0, o_data}, {24'd0, alt_data[i]});
      check("alt_s", {31'd0, s}, {31'd0, alt_s[i]});
    end

    // Only B for two cycles, then both: A must win next
    a_valid = 1'b0; b_data = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bonly_data", {24'd0, o_data}, 32'h5A);
      check("bonly_s", {31'd0, s}, 32'd1);
    end
    a_valid = 1'b1; a_data = 8'h11;
    tick();
    check("after_b_s", {31'd0, s}, 32'd0);
    check("after_b_data", {24'd0, o_data}, 32'h11);

    // Load A=33, stall 3 cycles with both valid, then B wins on release
    b_valid = 1'b0; a_data = 8'h33;
    tick();
    check("load33_data", {24'd0, o_data}, 32'h33);
    o_ready = 1'b0; b_valid = 1'b1; b_data = 8'h44; a_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data", {24'd0, o_data}, 32'h33);
      check("stall_s", {31'd0, s}, 32'd0);
      check("stall_valid", {31'd0, o_valid}, 32'd1);
    end
    o_ready = 1'b1;
    tick();
    check("unstall_s", {31'd0, s}, 32'd1);
    check("unstall_data", {24'd0, o_data}, 32'h44);

    // Continuous A, then drop valids: o_valid falls, data holds
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = 8'(8'h60 + i);
      tick();
      check("a_run_data", {24'd0, o_data}, {24'd0, 8'(8'h60 + i)});
    end
    a_valid = 1'b0;
    tick();
    check("drain_valid", {31'd0, o_valid}, 32'd0);
    check("drain_hold", {24'd0, o_data}, 32'h62);

    // Reset while holding a stalled entry with both channels requesting
    a_valid = 1'b1; a_data = 8'h77;
    tick();
    o_ready = 1'b0; b_valid = 1'b1; b_data = 8'h88; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_data", {24'd0, o_data}, 32'd0);
    check("mid_rst_s", {31'd0, s}, 32'd0);
    o_ready = 1'b1;
    tick();
    check("post_rst_s", {31'd0, s}, 32'd0);
    check("post_rst_data", {24'd0, o_data}, 32'h77);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      o_ready = ($urandom_range(0, 3) != 0);
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      tick();
    end

    // Drain whatever is left
    a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
    tick();
    tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
